// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the decode stage: opcodes, immediate formats,
// ALU op encodings and the decoded-instruction bundle held in the output register.
package riscv_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    // funct3 of the shift-right group, the only OP-IMM case where funct7[5] matters
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        use_imm;
        logic        use_pc;
        logic        illegal;
    } id_bundle_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic rs1_used(input logic [6:0] opcode);
        return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] opcode);
        return (opcode == OPC_OP || opcode == OPC_BRANCH || opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the sign-extended immediate format
// from the opcode; formats without an immediate (OP, FENCE, illegal) give 0.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt(inst_i[6:0]);

    always_comb begin
        imm_o = '0;
        case (fmt)
            IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            IMM_U: imm_o = {inst_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry registered output toward execute, with
// load-use hazard stall, flush squash and register-file address steering.
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    output logic [4:0]  rs1i,
    output logic [4:0]  rs2i,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rd,
    output logic [31:0] id_imm,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_jalr,
    output logic        id_use_imm,
    output logic        id_use_pc,
    output logic        id_illegal
);

    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    id_bundle_t  dec;
    id_bundle_t  id_q, id_d;
    logic        valid_q, valid_d;
    logic        load_use;
    logic        hazard;
    logic        accept;

    imm_gen u_imm_gen (
        .inst_i (if_inst),
        .imm_o  (imm)
    );

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];

    always_comb begin
        dec        = '0;
        dec.pc     = if_pc;
        dec.rd     = if_inst[11:7];
        dec.rs1    = if_inst[19:15];
        dec.rs2    = if_inst[24:20];
        dec.imm    = imm;
        dec.funct3 = funct3;
        dec.alu_op = ALU_ADD;
        // LUI/AUIPC/JAL/JALR feed the immediate into the adder; AUIPC/JAL add it to the PC
        case (opcode)
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.use_pc    = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.use_imm   = 1'b1;
                dec.use_pc    = 1'b1;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.use_imm   = 1'b1;
            end
            OPC_BRANCH: dec.branch = 1'b1;
            OPC_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.use_imm   = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.use_imm   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.alu_op    = (funct3 == F3_SR) ? {if_inst[30], funct3} : {1'b0, funct3};
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = {if_inst[30], funct3};
            end
            OPC_MISC_MEM: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign load_use = valid_q && id_q.mem_read && (id_q.rd != 5'd0);
    assign hazard   = load_use &&
                      (((id_q.rd == if_inst[19:15]) && rs1_used(opcode)) ||
                       ((id_q.rd == if_inst[24:20]) && rs2_used(opcode)));
    assign if_ready = flush || ((!valid_q || id_ready) && !hazard);
    assign accept   = if_valid && if_ready && !flush;

    // Outside the acceptance cycle the held instruction keeps addressing the register file
    assign rs1i = accept ? dec.rs1 : id_q.rs1;
    assign rs2i = accept ? dec.rs2 : id_q.rs2;

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            id_d    = dec;
        end else if (id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign id_valid     = valid_q;
    assign id_pc        = id_q.pc;
    assign id_rd        = id_q.rd;
    assign id_imm       = id_q.imm;
    assign id_funct3    = id_q.funct3;
    assign id_alu_op    = id_q.alu_op;
    assign id_reg_write = id_q.reg_write;
    assign id_mem_read  = id_q.mem_read;
    assign id_mem_write = id_q.mem_write;
    assign id_branch    = id_q.branch;
    assign id_jump      = id_q.jump;
    assign id_jalr      = id_q.jalr;
    assign id_use_imm   = id_q.use_imm;
    assign id_use_pc    = id_q.use_pc;
    assign id_illegal   = id_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have ports if_valid (in, 1), if_inst (in, 32) and if_pc (in, 32): fetched instruction and its PC.
REQ-004 SHALL have port if_ready, output, 1 bit: the instruction is accepted when if_valid && if_ready at posedge.
REQ-005 SHALL have port flush, input, 1 bit: branch/jump redirect from execute.
REQ-006 SHALL have ports rs1i and rs2i, output, 5 bits each: read addresses to the register file, which has 1-cycle synchronous read.
REQ-007 SHALL have ports id_valid (out, 1) and id_ready (in, 1): handshake toward execute.
REQ-008 SHALL have outputs id_pc (32), id_rd (5), id_imm (32), id_funct3 (3), id_alu_op (4), and one bit each for id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_jalr, id_use_imm, id_use_pc, id_illegal.

Function
REQ-009 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and MISC-MEM; FENCE SHALL decode as a NOP with all write/mem controls at 0.
REQ-010 Any other opcode, or inst[1:0] != 2'b11, SHALL set id_illegal=1 and clear id_reg_write, id_mem_read and id_mem_write.
REQ-011 id_alu_op SHALL be {funct7[5],funct3} for OP; for OP-IMM it SHALL be {funct7[5],funct3} when funct3=101 and {0,funct3} otherwise; it SHALL be 0000 (add) for all other opcodes.
REQ-012 id_imm SHALL be the sign-extended I, S, B, U or J immediate selected by opcode, and 0 for OP.
REQ-013 id_reg_write SHALL be 1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP with rd != 0.
REQ-014 Outputs SHALL be registered: there is 1 cycle of latency from acceptance to id_valid=1, aligned with the register file read data.
REQ-015 When id_valid && !id_ready, all id_* outputs SHALL hold stable.
REQ-016 rs1i/rs2i SHALL equal the if_inst fields on the cycle of acceptance; on all other cycles they SHALL equal the fields of the instruction held in the output register, so register file read data stays valid during a stall.
REQ-017 hazard SHALL be: id_valid && id_mem_read && id_rd != 0 && (id_rd == rs1 of if_inst and rs1 is used, or id_rd == rs2 of if_inst and rs2 is used).
REQ-018 rs1 SHALL count as used for every opcode except LUI, AUIPC and JAL; rs2 SHALL count as used only for OP, BRANCH and STORE.
REQ-019 if_ready SHALL be (!id_valid || id_ready) && !hazard, or 1 whenever flush=1.
REQ-020 When hazard && id_ready, the next cycle SHALL be a bubble (id_valid=0); the pending instruction SHALL be accepted in the following cycle, giving exactly one bubble.
REQ-021 flush SHALL take priority over everything else: next cycle id_valid=0, and any if_inst presented in the flush cycle SHALL be discarded.
REQ-022 When the output register is empty and if_valid=0, id_valid SHALL go to 0 on the next cycle.

Reset
REQ-023 On rst, id_valid and all id_* outputs SHALL be 0 on the next posedge.
REQ-024 After reset, if_ready SHALL be 1.
REQ-025 rst asserted during a stall or hazard SHALL discard the held instruction.

Structure
REQ-026 Opcode constants, ALU op encodings and immediate-format constants SHALL live in shared package riscv_pkg.
REQ-027 Immediate generation SHALL be a combinational sub-module imm_gen (inst in, opcode-selected imm out).
REQ-028 Hazard and handshake logic SHALL stay in decode_stage.

Verification
REQ-029 Present 0x00510093 (addi x1,x2,5) -> rs1i=2 at acceptance; next cycle id_valid=1, id_rd=1, id_imm=5, id_alu_op=0000, id_reg_write=1, id_use_imm=1.
REQ-030 Present 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7) with id_ready=1 -> one id_valid=0 bubble, then add emitted with rs1i=5 and rs2i=7.
REQ-031 Hold id_ready=0 for 3 cycles with the next instruction pending -> id_* outputs and rs1i/rs2i stable and if_ready=0; resumes with no loss or duplication.
REQ-032 Assert flush while add is in the output register and a new instruction is presented -> id_valid=0 next cycle and the presented instruction is never emitted.
REQ-033 Present 0xFFFFFFFF -> id_illegal=1, id_reg_write=0, id_mem_write=0.
REQ-034 Assert rst during a hazard bubble -> id_valid=0 and if_ready=1 the next cycle.
